calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Control/datapath stage directly upstream and downstream of the board I/O block.
- Consumes the switch nibble (User_Input0) and debounced button levels (User_Input1) that the I/O block produces.
- Sequences operand/opcode entry, executes a 4-bit arithmetic operation, and returns Result, State, overflow and underflow for display on the LEDs and seven-segment digits.
- Clocked by the divided CLK_In domain distributed by the I/O block.

Parameters:
- RESULT_MAX, 8'd99: largest legal Result. Larger true results saturate to this value and set overflow.

Ports:
- CLK  input  1  single clock (the CLK_In net from the I/O block); all state updates on the rising edge
- RST  input  1  asynchronous, active-high reset
- User_Input0  input  4  slide-switch value: operand or opcode source
- User_Input1  input  4  debounced button levels. [0]=ENTER, [1]=CLEAR, [2]=BACK, [3] unused
- Result  output  8  registered unsigned result
- State  output  4  registered state code, shown on the LEDs
- overflow  output  1  registered; true result exceeded RESULT_MAX, or divide by zero
- underflow  output  1  registered; subtraction went negative

Behaviour:
- Reset (async, RST=1):
  - state=S_A; State=4'b0001; Result=0; overflow=0; underflow=0.
  - A, B and op registers = 0.
  - Button-history register btn_prev = 4'b1111, so a button held through reset produces no edge until it is released and pressed again.
- Edge detect:
  - rise[i] = User_Input1[i] & ~btn_prev[i].
  - btn_prev <= User_Input1 on every clock.
  - One press gives exactly one action, however long it is held.
- Priority when several rises occur in the same cycle: CLEAR > BACK > ENTER. Only one action is taken per cycle.
- CLEAR, in any state: next state S_A; Result, overflow, underflow, A, B and op all cleared.
- States and State codes:
  - S_A (0001): ENTER -> A<=User_Input0, go to S_B.
  - S_B (0010): ENTER -> B<=User_Input0, go to S_OP. BACK -> S_A, A unchanged.
  - S_OP (0100): ENTER -> op<=User_Input0[1:0], go to S_EXEC. BACK -> S_B.
  - S_EXEC (1000): lasts exactly one cycle, ignores buttons, computes, then goes to S_SHOW.
  - S_SHOW (1111): ENTER -> S_A with Result and flags held. BACK -> S_OP, so the same operands can be re-executed with a new opcode.
- In S_A, BACK is ignored. ENTER pressed while in S_EXEC is lost; it is not queued.
- Arithmetic (A, B unsigned 4-bit; true result computed at 9 bits):
  - op 00 ADD: A+B.
  - op 01 SUB: if A>=B, A-B; else Result=0 and underflow=1.
  - op 10 MUL: A*B, maximum 225.
  - op 11 DIV: floor(A/B). If B=0: Result=RESULT_MAX, overflow=1.
  - Any true result > RESULT_MAX: Result=RESULT_MAX, overflow=1.
  - At most one of overflow and underflow is set.
- Output update:
  - Result, overflow and underflow load only on the clock edge that leaves S_EXEC; both flags are rewritten on every execute.
  - Otherwise they hold until the next execute, CLEAR or RST.
- Latency: the ENTER rise sampled in S_OP gives S_EXEC on that edge. Result, flags and State=1111 are valid one edge later.
- User_Input0 is sampled only on the ENTER edge. Switch changes at other times have no effect.
- RST asserted mid-sequence aborts immediately. No partial result is retained.

Test Plan:
- Reset with User_Input1[0] held high, then release RST -> State=0001, Result=0, flags 0. No transition occurs until the button is released and pressed again.
- A=7, B=5, op=00 via three ENTER presses -> after S_EXEC: Result=12, overflow=0, underflow=0, State=1111. Each press held 10 cycles causes exactly one transition.
- A=3, B=9, op=01 -> Result=0, underflow=1. Then BACK from S_SHOW, op=10 -> Result=27, underflow=0.
- A=15, B=15, op=10 -> true 225 > 99, so Result=99 and overflow=1. A=9, B=0, op=11 -> Result=99, overflow=1. A=14, B=4, op=11 -> Result=3.
- In S_OP, press CLEAR and ENTER in the same cycle -> State=0001, A=B=0, Result=0, no execute. BACK and ENTER in the same cycle in S_B -> S_A.
- Assert RST asynchronously while in S_EXEC -> outputs go to reset values immediately, without waiting for a clock edge. The prior Result is not loaded.

Source files
------------

// File: rtl/calc_sequencer.sv
// Operand/opcode entry sequencer with a 4-bit ADD/SUB/MUL/DIV execute stage.
// Button presses are rising-edge detected; results saturate at RESULT_MAX.
module calc_sequencer #(
    parameter logic [7:0] RESULT_MAX = 8'd99
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] User_Input0,
    input  logic [3:0] User_Input1,
    output logic [7:0] Result,
    output logic [3:0] State,
    output logic       overflow,
    output logic       underflow
);

    localparam int unsigned RES_W = 9;

    typedef enum logic [3:0] {
        S_A    = 4'b0001,
        S_B    = 4'b0010,
        S_OP   = 4'b0100,
        S_EXEC = 4'b1000,
        S_SHOW = 4'b1111
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [1:0] op_q, op_d;
    logic [3:0] btn_prev_q;
    logic [7:0] result_q, result_d;
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;

    logic enter_rise, clear_rise, back_rise;
    logic unused_btn;

    assign enter_rise = User_Input1[0] & ~btn_prev_q[0];
    assign clear_rise = User_Input1[1] & ~btn_prev_q[1];
    assign back_rise  = User_Input1[2] & ~btn_prev_q[2];
    assign unused_btn = User_Input1[3] ^ btn_prev_q[3];

    // Execute datapath: 9-bit true result, then saturation and flags
    logic [RES_W-1:0] true_res;
    logic             sub_neg, div_zero;
    logic [7:0]       exec_res;
    logic             exec_ovf, exec_unf;

    always_comb begin
        true_res = '0;
        sub_neg  = 1'b0;
        div_zero = 1'b0;
        case (op_q)
            2'b00: true_res = RES_W'(a_q) + RES_W'(b_q);
            2'b01: begin
                if (a_q >= b_q) true_res = RES_W'(a_q - b_q);
                else            sub_neg  = 1'b1;
            end
            2'b10: true_res = RES_W'(a_q) * RES_W'(b_q);
            default: begin
                if (b_q == 4'd0) div_zero = 1'b1;
                else             true_res = RES_W'(a_q / b_q);
            end
        endcase

        exec_res = true_res[7:0];
        exec_ovf = 1'b0;
        exec_unf = sub_neg;
        if (div_zero || (true_res > RES_W'(RESULT_MAX))) begin
            exec_res = RESULT_MAX;
            exec_ovf = 1'b1;
            exec_unf = 1'b0;
        end
    end

    // Next-state: execute ignores buttons, otherwise CLEAR > BACK > ENTER
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (state_q == S_EXEC) begin
            result_d = exec_res;
            ovf_d    = exec_ovf;
            unf_d    = exec_unf;
            state_d  = S_SHOW;
        end else if (clear_rise) begin
            state_d  = S_A;
            a_d      = '0;
            b_d      = '0;
            op_d     = '0;
            result_d = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else if (back_rise && (state_q != S_A)) begin
            case (state_q)
                S_B:     state_d = S_A;
                S_OP:    state_d = S_B;
                S_SHOW:  state_d = S_OP;
                default: state_d = state_q;
            endcase
        end else if (enter_rise) begin
            case (state_q)
                S_A: begin
                    a_d     = User_Input0;
                    state_d = S_B;
                end
                S_B: begin
                    b_d     = User_Input0;
                    state_d = S_OP;
                end
                S_OP: begin
                    op_d    = User_Input0[1:0];
                    state_d = S_EXEC;
                end
                S_SHOW:  state_d = S_A;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            btn_prev_q <= 4'b1111;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            btn_prev_q <= User_Input1;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign Result    = result_q;
    assign State     = state_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Randomized and directed bench for calc_sequencer against a behavioural calculator model.
module tb_calc_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] User_Input0 = '0;
    logic [3:0] User_Input1 = '0;
    logic [7:0] Result;
    logic [3:0] State;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_fail   = 0;

    calc_sequencer dut (
        .CLK         (CLK),
        .RST         (RST),
        .User_Input0 (User_Input0),
        .User_Input1 (User_Input1),
        .Result      (Result),
        .State       (State),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 CLK = ~CLK;

    // Model phases: 0=A 1=B 2=OP 3=EXEC 4=SHOW
    int       m_phase;
    int       m_a, m_b, m_op;
    int       m_res, m_ovf, m_unf;
    bit [3:0] m_prev;

    function automatic int phase_code(input int p);
        case (p)
            0: return 1;
            1: return 2;
            2: return 4;
            3: return 8;
            default: return 15;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_a = 0; m_b = 0; m_op = 0;
        m_res = 0; m_ovf = 0; m_unf = 0;
        m_prev = 4'b1111;
    endtask

    task automatic model_compute();
        int t;
        m_ovf = 0;
        m_unf = 0;
        t = 0;
        case (m_op)
            0: t = m_a + m_b;
            1: if (m_a >= m_b) t = m_a - m_b; else m_unf = 1;
            2: t = m_a * m_b;
            default: if (m_b == 0) m_ovf = 1; else t = m_a / m_b;
        endcase
        if (m_ovf == 1 || t > 99) begin
            t = 99;
            m_ovf = 1;
        end
        m_res = t;
    endtask

    task automatic model_edge(input int sw, input bit [3:0] btn);
        bit [3:0] rise;
        rise   = btn & ~m_prev;
        m_prev = btn;
        if (m_phase == 3) begin
            model_compute();
            m_phase = 4;
        end else if (rise[1]) begin
            model_reset();
            m_prev = btn;
        end else if (rise[2] && m_phase != 0) begin
            m_phase = (m_phase == 4) ? 2 : m_phase - 1;
        end else if (rise[0]) begin
            case (m_phase)
                0: begin m_a = sw; m_phase = 1; end
                1: begin m_b = sw; m_phase = 2; end
                2: begin m_op = sw % 4; m_phase = 3; end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic check_all();
        check("state",     32'(State),     32'(phase_code(m_phase)));
        check("result",    32'(Result),    32'(m_res));
        check("overflow",  32'(overflow),  32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
    endtask

    task automatic step(input int sw, input bit [3:0] btn);
        @(negedge CLK);
        User_Input0 = 4'(sw);
        User_Input1 = btn;
        @(posedge CLK);
        model_edge(sw, btn);
        #1;
        check_all();
    endtask

    task automatic press(input int sw, input bit [3:0] btn, input int hold);
        for (int i = 0; i < hold; i++) step(sw, btn);
        step(0, 4'b0000);
    endtask

    task automatic calc(input int a, input int b, input int op);
        press(a, 4'b0001, 10);
        press(b, 4'b0001, 10);
        press(op, 4'b0001, 10);
    endtask

    initial begin
        // Reset with ENTER held: no action until released and pressed again
        @(negedge CLK);
        RST = 1'b1;
        User_Input1 = 4'b0001;
        model_reset();
        #1;
        check("rst_state",  32'(State),  32'd1);
        check("rst_result", 32'(Result), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) step(3, 4'b0001);
        check("held_enter", 32'(State), 32'd1);
        step(0, 4'b0000);

        calc(7, 5, 0);
        check("add_res",   32'(Result), 32'd12);
        check("add_state", 32'(State),  32'd15);
        press(0, 4'b0001, 2);

        calc(3, 9, 1);
        check("sub_res", 32'(Result),    32'd0);
        check("sub_unf", 32'(underflow), 32'd1);
        press(0, 4'b0100, 3);
        press(2, 4'b0001, 3);
        check("mul_res", 32'(Result),    32'd27);
        check("mul_unf", 32'(underflow), 32'd0);
        press(0, 4'b0001, 2);

        calc(15, 15, 2);
        check("sat_res", 32'(Result),   32'd99);
        check("sat_ovf", 32'(overflow), 32'd1);
        press(0, 4'b0001, 2);
        calc(9, 0, 3);
        check("div0_res", 32'(Result),   32'd99);
        check("div0_ovf", 32'(overflow), 32'd1);
        press(0, 4'b0001, 2);
        calc(14, 4, 3);
        check("div_res", 32'(Result),   32'd3);
        check("div_ovf", 32'(overflow), 32'd0);
        press(0, 4'b0001, 2);

        // CLEAR beats ENTER in S_OP; BACK beats ENTER in S_B
        press(5, 4'b0001, 2);
        press(6, 4'b0001, 2);
        press(1, 4'b0011, 2);
        check("clr_state",  32'(State),  32'd1);
        check("clr_result", 32'(Result), 32'd0);
        press(5, 4'b0001, 2);
        press(6, 4'b0101, 2);
        check("back_state", 32'(State), 32'd1);

        // Async reset while executing discards the pending result
        calc(6, 2, 0);
        check("pre_res", 32'(Result), 32'd8);
        press(0, 4'b0001, 2);
        press(2, 4'b0001, 2);
        press(3, 4'b0001, 2);
        step(0, 4'b0001);
        check("in_exec", 32'(State), 32'd8);
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        check("arst_state",  32'(State),     32'd1);
        check("arst_result", 32'(Result),    32'd0);
        check("arst_ovf",    32'(overflow),  32'd0);
        check("arst_unf",    32'(underflow), 32'd0);
        @(posedge CLK);
        #1;
        check_all();
        @(negedge CLK);
        RST = 1'b0;
        step(0, 4'b0000);
        step(0, 4'b0000);
        check("arst_hold", 32'(Result), 32'd0);

        // Random button/switch traffic against the model
        for (int i = 0; i < 600; i++) begin
            bit [3:0] btn;
            btn = '0;
            for (int k = 0; k < 4; k++) btn[k] = ($urandom_range(0, 3) == 0);
            step(int'($urandom_range(0, 15)), btn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
